// File: rtl/tile_ram_scheduler_if.sv
// rtl/tile_ram_scheduler_if.sv - game-logic request bus and tile RAM port bundle
//
// Purpose: groups the CPU req/ack handshake and the single-port tile RAM
//          signals that the scheduler arbitrates between.
// Signals:
//    cpu_req    game-logic request, held high until cpu_ack
//    cpu_we     1 = write, 0 = read, sampled with cpu_req
//    cpu_addr   game-logic tile address
//    cpu_wdata  write data
//    cpu_ack    one-cycle completion pulse
//    cpu_rdata  read data, valid in the cpu_ack cycle of a read
//    ram_en     RAM access strobe
//    ram_we     RAM write enable
//    ram_addr   RAM address
//    ram_wdata  RAM write data
//    ram_rdata  RAM read data, one cycle after a read strobe
// Modports:
//    slave      scheduler side
//    master     game logic plus RAM side
interface tile_ram_scheduler_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) ();
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      output cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      input  cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/tile_ram_scheduler.sv
// rtl/tile_ram_scheduler.sv - time-slot scheduler for the shared tile-map RAM
//
// Purpose: issues one display tile fetch per 16-pixel column at a fixed slot
//          derived from the timing counters; the slot always wins. All other
//          cycles serve game-logic reads/writes over a req/ack handshake.
// Ports:
//    pixel_clk  in   pixel clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    hcounter   in   horizontal count (0..HMAX)
//    vcounter   in   vertical count (0..VMAX)
//    bus        slave  CPU handshake and RAM port (tile_ram_scheduler_if)
//    tile_code  out  tile code of the tile currently being drawn
//    tile_load  out  one-cycle pulse when tile_code updates
module tile_ram_scheduler #(
   parameter int HMAX       = 800,
   parameter int VMAX       = 525,
   parameter int HLINES     = 640,
   parameter int VLINES     = 480,
   parameter int TILE_SHIFT = 4,
   parameter int MAP_COLS   = 40,
   parameter int FETCH_LEAD = 2,
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 8
) (
   input  logic               pixel_clk,
   input  logic               rst_n,
   input  logic [10:0]        hcounter,
   input  logic [10:0]        vcounter,
   tile_ram_scheduler_if.slave bus,
   output logic [DATA_W-1:0]  tile_code,
   output logic               tile_load
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [11:0] HMAX_W   = 12'(HMAX);
   localparam logic [11:0] HWRAP_W  = 12'(HMAX + 1);
   localparam logic [11:0] HLINES_W = 12'(HLINES);
   localparam logic [11:0] LEAD_W   = 12'(FETCH_LEAD);
   localparam logic [10:0] VMAX_W   = 11'(VMAX);
   localparam logic [10:0] VLINES_W = 11'(VLINES);

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              disp_p1_q;
   logic [DATA_W-1:0] tile_code_q, tile_code_d;
   logic              tile_load_q;

   // Look-ahead position: the fetch for a tile must be issued FETCH_LEAD
   // cycles before its first pixel, so it may belong to the next line.
   logic [11:0]       h_sum;
   logic              h_wrap;
   logic [11:0]       h_next;
   logic [10:0]       v_next;
   logic              disp_slot;
   logic [ADDR_W-1:0] disp_row;
   logic [ADDR_W-1:0] disp_col;
   logic [ADDR_W-1:0] disp_addr;

   always_comb begin
      h_sum  = {1'b0, hcounter} + LEAD_W;
      h_wrap = (h_sum > HMAX_W);
      h_next = h_wrap ? (h_sum - HWRAP_W) : h_sum;
      if (h_wrap)
         v_next = (vcounter == VMAX_W) ? 11'd0 : (vcounter + 11'd1);
      else
         v_next = vcounter;
      disp_slot = (h_next[TILE_SHIFT-1:0] == '0) && (h_next < HLINES_W) && (v_next < VLINES_W);
      // Address arithmetic is modulo 2**ADDR_W, so computing it directly in
      // ADDR_W bits gives the same truncated result as a wider product.
      disp_row  = ADDR_W'(v_next >> TILE_SHIFT);
      disp_col  = ADDR_W'(h_next >> TILE_SHIFT);
      disp_addr = disp_row * ADDR_W'(MAP_COLS) + disp_col;
   end

   // RAM issue and handshake FSM
   logic              ram_en_c;
   logic              ram_we_c;
   logic [ADDR_W-1:0] ram_addr_c;
   logic [DATA_W-1:0] ram_wdata_c;
   logic              cpu_ack_c;

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      rdata_d     = rdata_q;
      ram_en_c    = 1'b0;
      ram_we_c    = 1'b0;
      ram_addr_c  = '0;
      ram_wdata_c = '0;
      cpu_ack_c   = 1'b0;

      if (disp_slot) begin
         ram_en_c   = 1'b1;
         ram_addr_c = disp_addr;
      end

      case (state_q)
         S_IDLE: begin
            // A request colliding with a slot simply waits; the next cycle
            // is never a slot, so CPU latency stays bounded.
            if (bus.cpu_req && !disp_slot) begin
               ram_en_c    = 1'b1;
               ram_we_c    = bus.cpu_we;
               ram_addr_c  = bus.cpu_addr;
               ram_wdata_c = bus.cpu_wdata;
               we_d        = bus.cpu_we;
               state_d     = S_ACK;
            end
         end
         S_ACK: begin
            cpu_ack_c = 1'b1;
            if (!we_q)
               rdata_d = bus.ram_rdata;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            // Requester drops cpu_req after seeing the ack; this dead cycle
            // keeps a still-high request from being executed a second time.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      tile_code_d = disp_p1_q ? bus.ram_rdata : tile_code_q;
   end

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         rdata_q     <= '0;
         disp_p1_q   <= 1'b0;
         tile_code_q <= '0;
         tile_load_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         rdata_q     <= rdata_d;
         disp_p1_q   <= disp_slot;
         tile_code_q <= tile_code_d;
         tile_load_q <= disp_p1_q;
      end
   end

   // Strobes are gated with rst_n so the RAM sees no access while in reset.
   assign bus.ram_en    = rst_n & ram_en_c;
   assign bus.ram_we    = rst_n & ram_we_c;
   assign bus.ram_addr  = ram_addr_c;
   assign bus.ram_wdata = ram_wdata_c;
   assign bus.cpu_ack   = cpu_ack_c;
   // Read data is forwarded straight from the RAM during the ack cycle and
   // held in rdata_q afterwards.
   assign bus.cpu_rdata = (state_q == S_ACK && !we_q) ? bus.ram_rdata : rdata_q;

   assign tile_code = tile_code_q;
   assign tile_load = tile_load_q;

endmodule
